axis64_pkt_buffer: RTL and testbench
====================================

AXIS64_PKT_BUFFER -- requirements
Module: axis64_pkt_buffer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 512, meaning data store size in 64-bit beats (power of 2, 16..4096).
REQ-002 The block SHALL have parameter MAX_PKTS, default 64, meaning maximum committed packets held (power of 2).
REQ-003 The block SHALL have port clk_390, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port clk_390_rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have ports s_tdata in 64, s_tkeep in 8, s_tuser in 64, s_tlast in 1, s_tvalid in 1 and s_tready out 1, forming the AXI-Stream sink from the KVS core.
REQ-006 The block SHALL have ports m_tdata out 64, m_tkeep out 8, m_tuser out 64, m_tlast out 1, m_tvalid out 1 and m_tready in 1, forming the AXI-Stream source toward the network MAC.
REQ-007 The block SHALL have ports pkt_count out log2(MAX_PKTS)+1 (committed packets held) and drop_pulse out 1 (one-cycle strobe per dropped packet).

Function
REQ-008 A beat SHALL transfer on either side only in a cycle where valid and ready are both high at the rising edge.
REQ-009 Store-and-forward: no beat of a packet SHALL appear on m_* before that packet's s_tlast beat is accepted.
REQ-010 On acceptance of s_tlast, the packet SHALL be committed: the commit pointer takes the write pointer and pkt_count increments.
REQ-011 m_tvalid SHALL rise no earlier than, and exactly, one cycle after the commit edge when the output is idle.
REQ-012 The output SHALL be a registered first-word-fall-through stage, so m_* is stable while m_tvalid=1 and m_tready=0.
REQ-013 With m_tready held high, beats of one packet SHALL be presented back-to-back with no bubbles.
REQ-014 pkt_count SHALL decrement on the cycle the m_tlast beat transfers.
REQ-015 On a simultaneous commit and drain in one cycle, pkt_count SHALL remain unchanged.
REQ-016 s_tready SHALL be low when the store is full (DEPTH beats written but not yet drained), or when pkt_count==MAX_PKTS and the write pointer equals the commit pointer.
REQ-017 The write FSM SHALL have states WRITE (reset state) and DROP.
REQ-018 WRITE->DROP SHALL occur when the store is full, pkt_count==0 and a packet is in progress (oversize packet): the write pointer rewinds to the commit pointer.
REQ-019 In DROP, s_tready SHALL be 1 and accepted beats SHALL be discarded.
REQ-020 On accepting s_tlast in DROP, the FSM SHALL return to WRITE and drop_pulse SHALL be 1 for one cycle; nothing is committed.
REQ-021 A 1-beat packet (s_tlast on first beat) SHALL be legal; tkeep and tuser SHALL pass unmodified; pointers SHALL wrap modulo DEPTH.

Reset
REQ-022 Asserting clk_390_rst_n low SHALL immediately clear all pointers, pkt_count, FSM (to WRITE) and outputs: m_tvalid=0, m_tlast=0, m_tdata=0, m_tkeep=0, m_tuser=0, s_tready=0, drop_pulse=0.
REQ-023 s_tready SHALL rise on the first edge after deassertion.
REQ-024 A reset mid-packet SHALL discard all buffered and partial data.

Configuration
REQ-025 With macro AXIS64_PKTBUF_STATS_EN defined, the block SHALL add outputs stat_rx_pkts, stat_tx_pkts and stat_drop_pkts (32 bits each): saturating counts of commits, m_tlast transfers and drops, cleared by reset.
REQ-026 Without AXIS64_PKTBUF_STATS_EN, those ports and counters SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-027 Send a 3-beat packet (tkeep FF,FF,0F) with m_tready=1 -> m_tvalid rises one cycle after the s_tlast edge; 3 identical beats out; pkt_count 0->1->0.
REQ-028 Hold m_tready=0 and send 4 packets of 8 beats with MAX_PKTS=4 -> pkt_count=4, s_tready=0; release m_tready -> 32 beats in order, no bubbles.
REQ-029 With DEPTH=16, send a 20-beat packet followed by a 2-beat packet -> one drop_pulse, no output for the first packet, the 2-beat packet delivered intact.
REQ-030 Assert reset after beat 2 of a 5-beat packet -> all outputs 0 immediately; the next 1-beat packet is delivered alone.
REQ-031 Stream 1000 random-length (1-16 beat) packets with random m_tready -> output equals input, with wrap-around exercised and pkt_count never exceeding MAX_PKTS.
REQ-032 With AXIS64_PKTBUF_STATS_EN defined, run REQ-029 -> stat_rx_pkts=1, stat_tx_pkts=1, stat_drop_pkts=1.

Source files
------------

// File: rtl/axis64_pkt_buffer.sv
// axis64_pkt_buffer: store-and-forward AXI-Stream packet buffer, 64-bit beats.
// A packet becomes visible on m_* only after its s_tlast beat is accepted
// (committed). Packets larger than the store are discarded whole.
// Optional statistics counters are enabled by defining AXIS64_PKTBUF_STATS_EN.
//
// Handshake: a beat moves on either port only on a rising clk_390 edge where
// tvalid and tready are both high; m_* holds steady while m_tvalid=1 and
// m_tready=0.
module axis64_pkt_buffer #(
  parameter int DEPTH    = 512,
  parameter int MAX_PKTS = 64
) (
  input  logic                          clk_390,
  input  logic                          clk_390_rst_n,
  input  logic [63:0]                   s_tdata,
  input  logic [7:0]                    s_tkeep,
  input  logic [63:0]                   s_tuser,
  input  logic                          s_tlast,
  input  logic                          s_tvalid,
  output logic                          s_tready,
  output logic [63:0]                   m_tdata,
  output logic [7:0]                    m_tkeep,
  output logic [63:0]                   m_tuser,
  output logic                          m_tlast,
  output logic                          m_tvalid,
  input  logic                          m_tready,
  output logic [$clog2(MAX_PKTS):0]     pkt_count,
  output logic                          drop_pulse
`ifdef AXIS64_PKTBUF_STATS_EN
  ,
  output logic [31:0]                   stat_rx_pkts,
  output logic [31:0]                   stat_tx_pkts,
  output logic [31:0]                   stat_drop_pkts
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(MAX_PKTS) + 1;
  localparam int BW = 64 + 8 + 64 + 1;
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_PKTS);

  localparam logic [0:0] ST_WRITE = 1'b0;
  localparam logic [0:0] ST_DROP  = 1'b1;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]    r_wr_ptr;
  logic [AW:0]    r_cmt_ptr;
  logic [AW:0]    r_rd_ptr;
  logic [CW-1:0]  r_pkt_count;
  logic [0:0]     r_state;
  logic           r_rdy_en;
  logic           r_drop_pulse;
  logic           r_m_tvalid;
  logic           r_m_tlast;
  logic [63:0]    r_m_tdata;
  logic [7:0]     r_m_tkeep;
  logic [63:0]    r_m_tuser;
  logic [BW-1:0]  r_mem [DEPTH];

  logic [AW:0]    w_used;
  logic           w_full;
  logic           w_s_ready;
  logic           w_s_fire;
  logic           w_wr_en;
  logic           w_commit;
  logic           w_oversize;
  logic           w_drop_end;
  logic           w_m_fire;
  logic           w_m_last_fire;
  logic           w_load;
  logic [BW-1:0]  w_rd_word;

  // Occupancy counts beats written but not yet moved into the output register.
  assign w_used        = r_wr_ptr - r_rd_ptr;
  assign w_full        = w_used[AW];
  assign w_s_ready     = r_rdy_en & ((r_state == ST_DROP) |
                         (~w_full & ~((r_pkt_count == MAX_CNT) & (r_wr_ptr == r_cmt_ptr))));
  assign w_s_fire      = s_tvalid & w_s_ready;
  assign w_wr_en       = w_s_fire & (r_state == ST_WRITE);
  assign w_commit      = w_wr_en & s_tlast;
  // Store full with nothing committed means the packet in flight can never fit.
  assign w_oversize    = (r_state == ST_WRITE) & w_full & (r_pkt_count == '0) &
                         (r_wr_ptr != r_cmt_ptr);
  assign w_drop_end    = w_s_fire & (r_state == ST_DROP) & s_tlast;
  assign w_m_fire      = r_m_tvalid & m_tready;
  assign w_m_last_fire = w_m_fire & r_m_tlast;
  assign w_load        = (~r_m_tvalid | m_tready) & (r_rd_ptr != r_cmt_ptr);
  assign w_rd_word     = r_mem[r_rd_ptr[AW-1:0]];

  assign s_tready   = w_s_ready;
  assign m_tvalid   = r_m_tvalid;
  assign m_tlast    = r_m_tlast;
  assign m_tdata    = r_m_tdata;
  assign m_tkeep    = r_m_tkeep;
  assign m_tuser    = r_m_tuser;
  assign pkt_count  = r_pkt_count;
  assign drop_pulse = r_drop_pulse;

  // Beat storage; contents are meaningless until covered by the pointers.
  always_ff @(posedge clk_390) begin
    if (w_wr_en) r_mem[r_wr_ptr[AW-1:0]] <= {s_tlast, s_tuser, s_tkeep, s_tdata};
  end

  // Write side: pointers, write/drop FSM and the drop strobe.
  always_ff @(posedge clk_390 or negedge clk_390_rst_n) begin
    if (!clk_390_rst_n) begin
      r_wr_ptr     <= '0;
      r_cmt_ptr    <= '0;
      r_state      <= ST_WRITE;
      r_rdy_en     <= 1'b0;
      r_drop_pulse <= 1'b0;
    end else begin
      r_rdy_en     <= 1'b1;
      r_drop_pulse <= w_drop_end;
      if (r_state == ST_WRITE) begin
        if (w_oversize) begin
          r_state  <= ST_DROP;
          r_wr_ptr <= r_cmt_ptr;
        end else if (w_wr_en) begin
          r_wr_ptr <= r_wr_ptr + 1'b1;
          if (s_tlast) r_cmt_ptr <= r_wr_ptr + 1'b1;
        end
      end else if (w_drop_end) begin
        r_state <= ST_WRITE;
      end
    end
  end

  // Committed packet count: up on commit, down on the m_tlast transfer.
  always_ff @(posedge clk_390 or negedge clk_390_rst_n) begin
    if (!clk_390_rst_n) begin
      r_pkt_count <= '0;
    end else begin
      case ({w_commit, w_m_last_fire})
        2'b10:   r_pkt_count <= r_pkt_count + 1'b1;
        2'b01:   r_pkt_count <= r_pkt_count - 1'b1;
        default: r_pkt_count <= r_pkt_count;
      endcase
    end
  end

  // Registered first-word-fall-through output stage fed from committed beats.
  always_ff @(posedge clk_390 or negedge clk_390_rst_n) begin
    if (!clk_390_rst_n) begin
      r_rd_ptr   <= '0;
      r_m_tvalid <= 1'b0;
      r_m_tlast  <= 1'b0;
      r_m_tdata  <= '0;
      r_m_tkeep  <= '0;
      r_m_tuser  <= '0;
    end else if (w_load) begin
      r_rd_ptr   <= r_rd_ptr + 1'b1;
      r_m_tvalid <= 1'b1;
      r_m_tlast  <= w_rd_word[BW-1];
      r_m_tuser  <= w_rd_word[135:72];
      r_m_tkeep  <= w_rd_word[71:64];
      r_m_tdata  <= w_rd_word[63:0];
    end else if (w_m_fire) begin
      r_m_tvalid <= 1'b0;
    end
  end

`ifdef AXIS64_PKTBUF_STATS_EN
  logic [31:0] r_stat_rx;
  logic [31:0] r_stat_tx;
  logic [31:0] r_stat_drop;

  assign stat_rx_pkts   = r_stat_rx;
  assign stat_tx_pkts   = r_stat_tx;
  assign stat_drop_pkts = r_stat_drop;

  // Saturating event counters for commits, transmitted packets and drops.
  always_ff @(posedge clk_390 or negedge clk_390_rst_n) begin
    if (!clk_390_rst_n) begin
      r_stat_rx   <= '0;
      r_stat_tx   <= '0;
      r_stat_drop <= '0;
    end else begin
      if (w_commit && (r_stat_rx != '1))        r_stat_rx   <= r_stat_rx + 1'b1;
      if (w_m_last_fire && (r_stat_tx != '1))   r_stat_tx   <= r_stat_tx + 1'b1;
      if (w_drop_end && (r_stat_drop != '1))    r_stat_drop <= r_stat_drop + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_axis64_pkt_buffer.sv
// tb_axis64_pkt_buffer: randomized bench with a packet-level reference model.
// The model keeps committed beats in an expected queue and the packet count as
// plain integers; a negedge process compares the DUT against it every cycle.
module tb_axis64_pkt_buffer;
  localparam int DEPTH    = 32;
  localparam int MAX_PKTS = 4;
  localparam int CW       = $clog2(MAX_PKTS) + 1;
  localparam int BW       = 137;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [63:0]   s_tdata = '0;
  logic [7:0]    s_tkeep = '0;
  logic [63:0]   s_tuser = '0;
  logic          s_tlast = 1'b0;
  logic          s_tvalid = 1'b0;
  logic          s_tready;
  logic [63:0]   m_tdata;
  logic [7:0]    m_tkeep;
  logic [63:0]   m_tuser;
  logic          m_tlast;
  logic          m_tvalid;
  logic          m_tready = 1'b0;
  logic [CW-1:0] pkt_count;
  logic          drop_pulse;
`ifdef AXIS64_PKTBUF_STATS_EN
  logic [31:0]   stat_rx_pkts, stat_tx_pkts, stat_drop_pkts;
`endif

  axis64_pkt_buffer #(.DEPTH(DEPTH), .MAX_PKTS(MAX_PKTS)) u_dut (
    .clk_390(clk), .clk_390_rst_n(rst_n),
    .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tuser(s_tuser), .s_tlast(s_tlast),
    .s_tvalid(s_tvalid), .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tuser(m_tuser), .m_tlast(m_tlast),
    .m_tvalid(m_tvalid), .m_tready(m_tready),
    .pkt_count(pkt_count), .drop_pulse(drop_pulse)
`ifdef AXIS64_PKTBUF_STATS_EN
    , .stat_rx_pkts(stat_rx_pkts), .stat_tx_pkts(stat_tx_pkts), .stat_drop_pkts(stat_drop_pkts)
`endif
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model state
  logic [BW-1:0] exp_q[$];
  logic [BW-1:0] part_q[$];
  logic [BW-1:0] popped;
  int  exp_cnt = 0;
  bit  exp_drop = 0;
  bit  avail_prev = 0;
  bit  chk_en = 0;
  int  n_chk = 0;
  int  n_pass = 0;
  int  drop_seen = 0;
  int  out_beats = 0;
  int  rdy_mode = 0;

  task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic timeout_fail(input string name);
    n_chk++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // Scoreboard: compare current outputs, then record the transfers that the
  // next rising edge will perform.
  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      chk("pkt_count", BW'(pkt_count), BW'(exp_cnt));
      chk("drop_pulse", BW'(drop_pulse), BW'(exp_drop));
      if (drop_pulse) drop_seen++;
      if (m_tvalid) begin
        if (exp_q.size() == 0) chk("m_tvalid_uncommitted", BW'(m_tvalid), BW'(0));
        else chk("m_beat", {m_tlast, m_tuser, m_tkeep, m_tdata}, exp_q[0]);
      end
      if (avail_prev) chk("m_tvalid_ready_beat", BW'(m_tvalid), BW'(1));
      if (m_tvalid && m_tready && exp_q.size() > 0) begin
        popped = exp_q.pop_front();
        out_beats++;
        if (popped[BW-1]) exp_cnt--;
      end
      avail_prev = (exp_q.size() > 0);
      exp_drop = 0;
      if (s_tvalid && s_tready) begin
        part_q.push_back({s_tlast, s_tuser, s_tkeep, s_tdata});
        if (s_tlast) begin
          if (part_q.size() > DEPTH) exp_drop = 1;
          else begin
            foreach (part_q[i]) exp_q.push_back(part_q[i]);
            exp_cnt++;
          end
          part_q.delete();
        end
      end
    end
  end

  // Random backpressure on the output side
  always @(posedge clk) begin
    if (rdy_mode == 2) begin
      #1;
      m_tready = 1'($urandom_range(0, 1));
    end
  end

  // Driver tasks
  task automatic send_beat(input logic [63:0] d, input logic [7:0] k,
                           input logic [63:0] u, input logic l);
    int t = 0;
    s_tdata = d; s_tkeep = k; s_tuser = u; s_tlast = l; s_tvalid = 1'b1;
    @(negedge clk);
    while (!s_tready) begin
      t++;
      if (t > 3000) begin
        timeout_fail("s_tready_wait");
        break;
      end
      @(negedge clk);
    end
    @(posedge clk); #1;
    s_tvalid = 1'b0;
  endtask

  task automatic send_pkt(input int len, input bit gaps);
    for (int i = 0; i < len; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
      send_beat({$urandom, $urandom}, 8'($urandom), {$urandom, $urandom}, (i == len - 1));
    end
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((exp_q.size() != 0 || exp_cnt != 0) && t < 6000) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 6000) timeout_fail("drain");
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    chk_en = 0;
    rst_n = 1'b0;
    s_tvalid = 1'b0;
    exp_q.delete(); part_q.delete();
    exp_cnt = 0; exp_drop = 0; avail_prev = 0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("s_tready_before_edge", BW'(s_tready), BW'(0));
    @(posedge clk); #1;
    chk("s_tready_after_edge", BW'(s_tready), BW'(1));
    chk_en = 1;
  endtask

  int out0;
  int drop0;

  initial begin
    // Reset state
    #1 rst_n = 1'b0;
    #1;
    chk("rst_m_tvalid", BW'(m_tvalid), BW'(0));
    chk("rst_s_tready", BW'(s_tready), BW'(0));
    chk("rst_pkt_count", BW'(pkt_count), BW'(0));
    chk("rst_m_tdata", BW'(m_tdata), BW'(0));
    chk("rst_drop_pulse", BW'(drop_pulse), BW'(0));
    do_reset();

    // 3-beat packet, m_tready high: valid one cycle after the commit edge
    m_tready = 1'b1;
    send_beat(64'h1111_2222_3333_4444, 8'hFF, 64'h0000_0000_0000_00A0, 1'b0);
    send_beat(64'h5555_6666_7777_8888, 8'hFF, 64'h0000_0000_0000_00A1, 1'b0);
    send_beat(64'h9999_AAAA_BBBB_CCCC, 8'h0F, 64'h0000_0000_0000_00A2, 1'b1);
    chk("p3_count_after_commit", BW'(pkt_count), BW'(1));
    chk("p3_valid_low_at_commit", BW'(m_tvalid), BW'(0));
    @(posedge clk); #1;
    chk("p3_valid_rise", BW'(m_tvalid), BW'(1));
    chk("p3_beat0_data", BW'(m_tdata), BW'(64'h1111_2222_3333_4444));
    chk("p3_beat0_keep", BW'(m_tkeep), BW'(8'hFF));
    @(posedge clk); #1;
    chk("p3_beat1_data", BW'(m_tdata), BW'(64'h5555_6666_7777_8888));
    @(posedge clk); #1;
    chk("p3_beat2_data", BW'(m_tdata), BW'(64'h9999_AAAA_BBBB_CCCC));
    chk("p3_beat2_keep", BW'(m_tkeep), BW'(8'h0F));
    chk("p3_beat2_user", BW'(m_tuser), BW'(64'hA2));
    chk("p3_beat2_last", BW'(m_tlast), BW'(1));
    @(posedge clk); #1;
    chk("p3_count_drained", BW'(pkt_count), BW'(0));
    chk("p3_valid_fall", BW'(m_tvalid), BW'(0));

    // Four 8-beat packets held back: count saturates at MAX_PKTS
    m_tready = 1'b0;
    for (int p = 0; p < 4; p++) send_pkt(8, 1'b0);
    chk("hold_pkt_count", BW'(pkt_count), BW'(4));
    chk("hold_s_tready", BW'(s_tready), BW'(0));
    m_tready = 1'b1;
    repeat (31) @(posedge clk);
    #1;
    chk("burst_count_31", BW'(pkt_count), BW'(1));
    @(posedge clk); #1;
    chk("burst_count_32", BW'(pkt_count), BW'(0));
    wait_drain();

    // Oversize packet is dropped, the following short one is delivered
    do_reset();
    m_tready = 1'b1;
    drop0 = drop_seen; out0 = out_beats;
    send_pkt(DEPTH + 8, 1'b0);
    send_pkt(2, 1'b0);
    wait_drain();
    chk("oversize_drop_pulses", BW'(drop_seen - drop0), BW'(1));
    chk("oversize_out_beats", BW'(out_beats - out0), BW'(2));
`ifdef AXIS64_PKTBUF_STATS_EN
    chk("stat_rx", BW'(stat_rx_pkts), BW'(1));
    chk("stat_tx", BW'(stat_tx_pkts), BW'(1));
    chk("stat_drop", BW'(stat_drop_pkts), BW'(1));
`endif

    // Reset mid-packet with a committed beat waiting on the output
    m_tready = 1'b0;
    send_pkt(1, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    send_beat(64'hDEAD_0000_0000_0001, 8'hFF, 64'h1, 1'b0);
    send_beat(64'hDEAD_0000_0000_0002, 8'hFF, 64'h2, 1'b0);
    chk_en = 0;
    rst_n = 1'b0;
    #1;
    chk("midrst_outputs", {m_tlast, m_tuser, m_tkeep, m_tdata},  BW'(0));
    chk("midrst_m_tvalid", BW'(m_tvalid), BW'(0));
    chk("midrst_s_tready", BW'(s_tready), BW'(0));
    chk("midrst_pkt_count", BW'(pkt_count), BW'(0));
    do_reset();
    m_tready = 1'b1;
    out0 = out_beats;
    send_beat(64'hBEEF_CAFE_0000_0001, 8'h01, 64'h77, 1'b1);
    wait_drain();
    chk("midrst_next_out_beats", BW'(out_beats - out0), BW'(1));

    // Long random run with random backpressure
    rdy_mode = 2;
    for (int p = 0; p < 1000; p++) send_pkt($urandom_range(1, 16), 1'b1);
    wait_drain();
    rdy_mode = 0;
    #2;
    m_tready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("final_pkt_count", BW'(pkt_count), BW'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
